// File: rtl/wave_channel.sv
// Programmable wave voice: steps through a 32 x 4-bit table at (2048-freq)*TIMER_MUL clocks per sample,
// with length counter and volume shift. Output is combinational from registered state.
module wave_channel #(
    parameter int TIMER_MUL = 2,
    parameter int TMR_W     = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk256,
    input  logic [127:0] wave_table,
    input  logic [10:0]  freq,
    input  logic [7:0]   len_load,
    input  logic [1:0]   vol_code,
    input  logic         dac_en,
    input  logic         trigger,
    input  logic         len_enable,
    output logic [3:0]   out,
    output logic         active,
    output logic [4:0]   pos
);

    logic             trigger_q;
    logic             clk256_q;
    logic [TMR_W-1:0] timer;
    logic [8:0]       length;
    logic [3:0]       buffer;
    logic             trg_edge;
    logic             tick;
    logic [TMR_W-1:0] reload;
    logic [4:0]       pos_next;
    logic [3:0]       sample_next;

    assign trg_edge    = trigger & ~trigger_q;
    assign tick        = clk256 & ~clk256_q;
    assign reload      = TMR_W'((2048 - int'(freq)) * TIMER_MUL);
    assign pos_next    = pos + 5'd1;
    assign sample_next = wave_table[{pos_next, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            // Edge registers track the inputs during reset so a level held high
            // across reset release does not look like a fresh rising edge.
            trigger_q <= trigger;
            clk256_q  <= clk256;
            timer     <= '0;
            length    <= '0;
            buffer    <= '0;
            active    <= 1'b0;
            pos       <= '0;
        end else begin
            trigger_q <= trigger;
            clk256_q  <= clk256;
            if (trg_edge) begin
                active <= dac_en;
                pos    <= '0;
                timer  <= reload;
                length <= 9'd256 - {1'b0, len_load};
            end else begin
                if (active) begin
                    if (timer == TMR_W'(1)) begin
                        timer  <= reload;
                        pos    <= pos_next;
                        buffer <= sample_next;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                if (tick && len_enable && length != 9'd0) begin
                    length <= length - 9'd1;
                    if (length == 9'd1)
                        active <= 1'b0;
                end
                if (!dac_en)
                    active <= 1'b0;
            end
        end
    end

    always_comb begin
        out = 4'd0;
        if (active && dac_en) begin
            case (vol_code)
                2'd1:    out = buffer;
                2'd2:    out = buffer >> 1;
                2'd3:    out = buffer >> 2;
                default: out = 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_channel.sv
// Randomized bench for wave_channel against an event-time reference model.
module tb_wave_channel;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk256;
    logic [127:0] wave_table;
    logic [10:0]  freq;
    logic [7:0]   len_load;
    logic [1:0]   vol_code;
    logic         dac_en;
    logic         trigger;
    logic         len_enable;
    logic [3:0]   out;
    logic         active;
    logic [4:0]   pos;

    always #5 clk = ~clk;

    wave_channel #(.TIMER_MUL(2), .TMR_W(13)) dut (
        .clk(clk), .reset(reset), .clk256(clk256), .wave_table(wave_table),
        .freq(freq), .len_load(len_load), .vol_code(vol_code), .dac_en(dac_en),
        .trigger(trigger), .len_enable(len_enable), .out(out), .active(active), .pos(pos)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;

    // Reference: the next sample step is an absolute cycle number, not a countdown.
    bit     m_active, m_trq, m_ckq;
    int     m_pos, m_buf, m_len;
    longint m_next;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic longint period(input int f);
        return longint'((2048 - f) * 2);
    endfunction

    task automatic model_edge();
        bit tr_e, tk;
        cyc++;
        tr_e  = trigger && !m_trq;
        tk    = clk256 && !m_ckq;
        m_trq = trigger;
        m_ckq = clk256;
        if (reset) begin
            m_active = 0; m_pos = 0; m_buf = 0; m_len = 0; m_next = 0;
        end else if (tr_e) begin
            m_active = dac_en;
            m_pos    = 0;
            m_next   = cyc + period(int'(freq));
            m_len    = 256 - int'(len_load);
        end else begin
            if (m_active && cyc == m_next) begin
                m_pos  = (m_pos + 1) % 32;
                m_buf  = int'(wave_table[m_pos*4 +: 4]);
                m_next = cyc + period(int'(freq));
            end
            if (tk && len_enable && m_len != 0) begin
                m_len--;
                if (m_len == 0) m_active = 0;
            end
            if (!dac_en) m_active = 0;
        end
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        model_edge();
        #1;
        e = 0;
        if (m_active && dac_en && vol_code != 2'd0) e = m_buf >> (int'(vol_code) - 1);
        chk("active", int'(active), int'(m_active));
        chk("pos", int'(pos), m_pos);
        chk("out", int'(out), e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic retrig();
        trigger = 1'b0; step();
        trigger = 1'b1; step();
    endtask

    task automatic pulse256();
        clk256 = 1'b1; step();
        clk256 = 1'b0; step();
    endtask

    initial begin
        m_active = 0; m_trq = 0; m_ckq = 0; m_pos = 0; m_buf = 0; m_len = 0; m_next = 0;
        reset = 1'b1; clk256 = 1'b0; trigger = 1'b0; freq = 11'd2047; len_load = 8'd0;
        vol_code = 2'd1; dac_en = 1'b1; len_enable = 1'b0;
        for (int n = 0; n < 32; n++) wave_table[n*4 +: 4] = 4'(n);
        run(3);
        reset = 1'b0;
        run(2);

        // Ramp table at the fastest rate, through a full wrap
        retrig();
        run(70);

        // Constant 14 under each volume code
        for (int n = 0; n < 32; n++) wave_table[n*4 +: 4] = 4'd14;
        run(4);
        for (int v = 1; v <= 4; v++) begin
            vol_code = 2'(v % 4);
            run(10);
        end
        vol_code = 2'd1;

        // Length expiry after two ticks, then length disabled
        len_load = 8'd254; len_enable = 1'b1;
        retrig();
        pulse256(); pulse256();
        chk("len_expired", int'(active), 0);
        len_enable = 1'b0;
        retrig();
        for (int i = 0; i < 10; i++) pulse256();
        chk("len_disabled", int'(active), 1);

        // DAC power off / blocked trigger / replay
        dac_en = 1'b0; run(3);
        retrig(); run(3);
        dac_en = 1'b1;
        retrig(); run(6);

        // Trigger coinciding with timer expiry and a tick
        len_enable = 1'b1; len_load = 8'd0; trigger = 1'b0; clk256 = 1'b0;
        step();
        for (int i = 0; i < 10 && !(m_active && m_next == cyc + 1); i++) step();
        trigger = 1'b1; clk256 = 1'b1; step();
        chk("coinc_pos", int'(pos), 0);
        trigger = 1'b0; clk256 = 1'b0; step();
        for (int i = 0; i < 255; i++) pulse256();
        chk("coinc_len255", int'(active), 1);
        pulse256();
        chk("coinc_len256", int'(active), 0);

        // Reset mid-play with trigger held high across release
        len_enable = 1'b0; freq = 11'd2044;
        for (int n = 0; n < 32; n++) wave_table[n*4 +: 4] = 4'(n | 1);
        retrig();
        begin
            int k;
            for (k = 0; k < 400 && m_pos != 17; k++) step();
            if (k >= 400) chk("wait_pos17", 0, 1);
        end
        reset = 1'b1; step();
        chk("rst_active", int'(active), 0);
        reset = 1'b0; run(20);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            trigger    = ($urandom_range(0, 9) == 0);
            clk256     = ($urandom_range(0, 3) == 0);
            freq       = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(0, 2047))
                                                      : 11'($urandom_range(2036, 2047));
            len_load   = 8'($urandom_range(200, 255));
            len_enable = 1'($urandom_range(0, 1));
            vol_code   = 2'($urandom_range(0, 3));
            dac_en     = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0)
                for (int n = 0; n < 4; n++) wave_table[n*32 +: 32] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
